// File: rtl/counter_bank_if.sv
// -----------------------------------------------------------------------------
// counter_bank_if
// Host readout bus for counter_bank. The host asks for a snapshot and then
// walks the captured counts 16 bits at a time.
//
// Signals:
//   snap_req    host -> bank  one-cycle pulse: capture all live counts
//   snap_sel    host -> bank  channel to read from the shadow registers
//   word_sel    host -> bank  16-bit word within the selected shadow
//   snap_valid  bank -> host  high once any snapshot has been captured
//   snap_word   bank -> host  selected 16-bit shadow word (combinational)
//
// Modports: master is the host side, slave is the counter bank.
// -----------------------------------------------------------------------------
interface counter_bank_if;
    logic        snap_req;
    logic [3:0]  snap_sel;
    logic [1:0]  word_sel;
    logic        snap_valid;
    logic [15:0] snap_word;

    modport master (
        output snap_req,
        output snap_sel,
        output word_sel,
        input  snap_valid,
        input  snap_word
    );

    modport slave (
        input  snap_req,
        input  snap_sel,
        input  word_sel,
        output snap_valid,
        output snap_word
    );
endinterface

// File: rtl/counter_bank.sv
// -----------------------------------------------------------------------------
// counter_bank
// Bank of N_CH up/down counters. Each channel can be reset, loaded, stepped
// up or down by trigger pulses, or advanced by a shared prescaled tick. Each
// channel wraps or saturates and keeps sticky overflow/underflow flags. A
// snapshot of every count can be captured on one edge and read back in
// 16-bit words, so wide counts are read without tearing.
//
// Ports:
//   clk1            sole clock, rising edge
//   reset_n         asynchronous active-low reset
//   trig_reset      per-channel pulse: count <= 0
//   trig_load       per-channel pulse: count <= load_value
//   trig_up         per-channel pulse: count + 1
//   trig_down       per-channel pulse: count - 1
//   load_value      load data shared by all channels
//   run_en          per-channel enable for prescaled auto-increment
//   sat_en          per-channel mode: 1 saturate, 0 wrap
//   prescale_div    tick every prescale_div+1 cycles
//   trig_clr_flags  pulse: clear all sticky flags
//   count_flat      live counts, channel i at [i*WIDTH +: WIDTH]
//   ovf_flag        sticky overflow per channel
//   unf_flag        sticky underflow per channel
//   snap_bus        host snapshot/readout bus (slave side)
// -----------------------------------------------------------------------------
module counter_bank #(
    parameter int N_CH       = 4,
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic                    clk1,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         trig_reset,
    input  logic [N_CH-1:0]         trig_load,
    input  logic [N_CH-1:0]         trig_up,
    input  logic [N_CH-1:0]         trig_down,
    input  logic [WIDTH-1:0]        load_value,
    input  logic [N_CH-1:0]         run_en,
    input  logic [N_CH-1:0]         sat_en,
    input  logic [PRESCALE_W-1:0]   prescale_div,
    input  logic                    trig_clr_flags,
    output logic [N_CH*WIDTH-1:0]   count_flat,
    output logic [N_CH-1:0]         ovf_flag,
    output logic [N_CH-1:0]         unf_flag,
    counter_bank_if.slave           snap_bus
);

    logic [PRESCALE_W-1:0] psc_cnt;
    logic                  tick;
    logic [WIDTH-1:0]      count  [N_CH];
    logic [WIDTH-1:0]      shadow [N_CH];
    logic                  snap_valid_q;

    // The tick fires when the divider reaches prescale_div. Using >= for the
    // wrap means a freshly lowered prescale_div below the current count sends
    // the counter straight back to 0 without producing a tick.
    assign tick = (psc_cnt == prescale_div);

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            psc_cnt <= '0;
        end else if (psc_cnt >= prescale_div) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + PRESCALE_W'(1);
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [WIDTH-1:0] count_nxt;
        logic             do_inc;
        logic             do_dec;
        logic             ovf_set;
        logic             unf_set;

        // Up and down together cancel; an explicit down beats a prescaler
        // tick. Reset and load sit above both and never raise flags.
        always_comb begin
            do_inc = 1'b0;
            do_dec = 1'b0;
            if (!trig_reset[ch] && !trig_load[ch]) begin
                if (trig_up[ch] && !trig_down[ch]) begin
                    do_inc = 1'b1;
                end else if (trig_down[ch] && !trig_up[ch]) begin
                    do_dec = 1'b1;
                end else if (!trig_up[ch] && run_en[ch] && tick) begin
                    do_inc = 1'b1;
                end
            end
        end

        always_comb begin
            count_nxt = count[ch];
            ovf_set   = 1'b0;
            unf_set   = 1'b0;
            if (trig_reset[ch]) begin
                count_nxt = '0;
            end else if (trig_load[ch]) begin
                count_nxt = load_value;
            end else if (do_inc) begin
                if (count[ch] == {WIDTH{1'b1}}) begin
                    ovf_set   = 1'b1;
                    count_nxt = sat_en[ch] ? count[ch] : '0;
                end else begin
                    count_nxt = count[ch] + WIDTH'(1);
                end
            end else if (do_dec) begin
                if (count[ch] == '0) begin
                    unf_set   = 1'b1;
                    count_nxt = sat_en[ch] ? '0 : {WIDTH{1'b1}};
                end else begin
                    count_nxt = count[ch] - WIDTH'(1);
                end
            end
        end

        // A flag event in the same cycle as a clear wins, so no event is lost.
        always_ff @(posedge clk1 or negedge reset_n) begin
            if (!reset_n) begin
                count[ch]    <= '0;
                ovf_flag[ch] <= 1'b0;
                unf_flag[ch] <= 1'b0;
            end else begin
                count[ch]    <= count_nxt;
                ovf_flag[ch] <= (ovf_flag[ch] & ~trig_clr_flags) | ovf_set;
                unf_flag[ch] <= (unf_flag[ch] & ~trig_clr_flags) | unf_set;
            end
        end

        // Shadows take the registered count, i.e. the value before this
        // edge's update, all on the same edge.
        always_ff @(posedge clk1 or negedge reset_n) begin
            if (!reset_n) begin
                shadow[ch] <= '0;
            end else if (snap_bus.snap_req) begin
                shadow[ch] <= count[ch];
            end
        end

        assign count_flat[ch*WIDTH +: WIDTH] = count[ch];
    end

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            snap_valid_q <= 1'b0;
        end else if (snap_bus.snap_req) begin
            snap_valid_q <= 1'b1;
        end
    end

    assign snap_bus.snap_valid = snap_valid_q;

    // Out-of-range channels read as 0, and the shadow is zero-extended to 64
    // bits so words above WIDTH also read as 0.
    logic [WIDTH-1:0] sel_shadow;
    logic [63:0]      sel_wide;

    always_comb begin
        sel_shadow = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (snap_bus.snap_sel == 4'(i)) begin
                sel_shadow = shadow[i];
            end
        end
        sel_wide = 64'(sel_shadow);
        case (snap_bus.word_sel)
            2'd0:    snap_bus.snap_word = sel_wide[15:0];
            2'd1:    snap_bus.snap_word = sel_wide[31:16];
            2'd2:    snap_bus.snap_word = sel_wide[47:32];
            default: snap_bus.snap_word = sel_wide[63:48];
        endcase
    end

endmodule

// File: tb/tb_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_counter_bank
// Self-checking bench for counter_bank with N_CH=4, WIDTH=32. Expected values
// are pushed to a scoreboard queue as stimulus is applied and popped and
// compared against the DUT once its outputs have settled.
// -----------------------------------------------------------------------------
module tb_counter_bank;
    localparam int N_CH       = 4;
    localparam int WIDTH      = 32;
    localparam int PRESCALE_W = 16;

    localparam int K_COUNT = 0;
    localparam int K_OVF   = 1;
    localparam int K_UNF   = 2;
    localparam int K_VALID = 3;
    localparam int K_WORD  = 4;

    typedef struct {
        string       tag;
        int          kind;
        int          ch;
        logic [63:0] val;
    } exp_t;

    logic                  clk1 = 1'b0;
    logic                  reset_n;
    logic [N_CH-1:0]       trig_reset;
    logic [N_CH-1:0]       trig_load;
    logic [N_CH-1:0]       trig_up;
    logic [N_CH-1:0]       trig_down;
    logic [WIDTH-1:0]      load_value;
    logic [N_CH-1:0]       run_en;
    logic [N_CH-1:0]       sat_en;
    logic [PRESCALE_W-1:0] prescale_div;
    logic                  trig_clr_flags;
    logic [N_CH*WIDTH-1:0] count_flat;
    logic [N_CH-1:0]       ovf_flag;
    logic [N_CH-1:0]       unf_flag;

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    counter_bank_if snap_bus ();

    counter_bank #(
        .N_CH       (N_CH),
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk1           (clk1),
        .reset_n        (reset_n),
        .trig_reset     (trig_reset),
        .trig_load      (trig_load),
        .trig_up        (trig_up),
        .trig_down      (trig_down),
        .load_value     (load_value),
        .run_en         (run_en),
        .sat_en         (sat_en),
        .prescale_div   (prescale_div),
        .trig_clr_flags (trig_clr_flags),
        .count_flat     (count_flat),
        .ovf_flag       (ovf_flag),
        .unf_flag       (unf_flag),
        .snap_bus       (snap_bus)
    );

    always #5 clk1 = ~clk1;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expect_val(input string tag, input int kind, input int ch,
                              input logic [63:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.ch   = ch;
        e.val  = val;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] observe(input int kind, input int ch);
        case (kind)
            K_COUNT: return 64'(count_flat[ch*WIDTH +: WIDTH]);
            K_OVF:   return 64'(ovf_flag);
            K_UNF:   return 64'(unf_flag);
            K_VALID: return 64'(snap_bus.snap_valid);
            default: return 64'(snap_bus.snap_word);
        endcase
    endfunction

    task automatic drainScoreboard();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.tag, observe(e.kind, e.ch), e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic clearTriggers();
        trig_reset     = '0;
        trig_load      = '0;
        trig_up        = '0;
        trig_down      = '0;
        trig_clr_flags = 1'b0;
        snap_bus.snap_req = 1'b0;
    endtask

    // Drives one cycle of triggers, lets the edge happen, then drops them.
    task automatic applyStimulus(input logic [N_CH-1:0] rst, input logic [N_CH-1:0] ld,
                                 input logic [N_CH-1:0] up, input logic [N_CH-1:0] dn,
                                 input logic clr, input logic snap);
        trig_reset        = rst;
        trig_load         = ld;
        trig_up           = up;
        trig_down         = dn;
        trig_clr_flags    = clr;
        snap_bus.snap_req = snap;
        step(1);
        clearTriggers();
    endtask

    initial begin
        reset_n           = 1'b0;
        clearTriggers();
        load_value        = '0;
        run_en            = '0;
        sat_en            = 4'b1010;
        prescale_div      = 16'd3;
        snap_bus.snap_sel = 4'd0;
        snap_bus.word_sel = 2'd0;

        #12;
        for (int i = 0; i < N_CH; i++) expect_val($sformatf("rst_cnt%0d", i), K_COUNT, i, 0);
        expect_val("rst_ovf", K_OVF, 0, 0);
        expect_val("rst_unf", K_UNF, 0, 0);
        expect_val("rst_valid", K_VALID, 0, 0);
        expect_val("rst_word", K_WORD, 0, 0);
        drainScoreboard();

        @(posedge clk1);
        #1;
        reset_n = 1'b1;
        step(1);

        applyStimulus(4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0);
        expect_val("up_ch1", K_COUNT, 1, 1);
        expect_val("up_ch0", K_COUNT, 0, 0);
        expect_val("up_ch2", K_COUNT, 2, 0);
        expect_val("up_ch3", K_COUNT, 3, 0);
        drainScoreboard();

        load_value = 32'hFFFF_FFFF;
        applyStimulus(4'b0000, 4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b0);
        expect_val("load_no_flag", K_OVF, 0, 0);
        drainScoreboard();
        applyStimulus(4'b0000, 4'b0000, 4'b0011, 4'b0000, 1'b0, 1'b0);
        expect_val("ovf_wrap_ch0", K_COUNT, 0, 0);
        expect_val("ovf_sat_ch1", K_COUNT, 1, 64'hFFFF_FFFF);
        expect_val("ovf_flags", K_OVF, 0, 4'b0011);
        drainScoreboard();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        expect_val("ovf_cleared", K_OVF, 0, 0);
        drainScoreboard();

        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b1100, 1'b0, 1'b0);
        expect_val("unf_wrap_ch2", K_COUNT, 2, 64'hFFFF_FFFF);
        expect_val("unf_sat_ch3", K_COUNT, 3, 0);
        expect_val("unf_flags", K_UNF, 0, 4'b1100);
        drainScoreboard();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

        load_value = 32'd5;
        applyStimulus(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0);
        expect_val("up_down_hold", K_COUNT, 0, 5);
        drainScoreboard();
        applyStimulus(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0);
        expect_val("reset_priority", K_COUNT, 0, 0);
        drainScoreboard();

        load_value = 32'hFFFF_FFFF;
        applyStimulus(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0);
        expect_val("clr_vs_ovf_flag", K_OVF, 0, 4'b0001);
        expect_val("clr_vs_ovf_cnt", K_COUNT, 0, 0);
        drainScoreboard();

        applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        run_en = 4'b0001;
        step(40);
        run_en = 4'b0000;
        expect_val("psc3_ch0", K_COUNT, 0, 10);
        expect_val("psc3_ch1", K_COUNT, 1, 0);
        expect_val("psc3_ch2", K_COUNT, 2, 0);
        drainScoreboard();

        prescale_div = 16'd0;
        step(1);
        run_en = 4'b0001;
        step(5);
        run_en = 4'b0000;
        expect_val("psc0_ch0", K_COUNT, 0, 15);
        drainScoreboard();

        load_value = 32'h1234_FFFF;
        run_en     = 4'b0010;
        applyStimulus(4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        snap_bus.snap_sel = 4'd1;
        snap_bus.word_sel = 2'd0;
        #1;
        expect_val("snap_valid", K_VALID, 0, 1);
        expect_val("snap_w0", K_WORD, 0, 16'hFFFF);
        expect_val("live_after_snap", K_COUNT, 1, 64'h1235_0000);
        drainScoreboard();
        step(2);
        snap_bus.word_sel = 2'd1;
        #1;
        expect_val("snap_w1", K_WORD, 0, 16'h1234);
        expect_val("live_running", K_COUNT, 1, 64'h1235_0002);
        drainScoreboard();
        snap_bus.word_sel = 2'd2;
        #1;
        expect_val("snap_w2_zero", K_WORD, 0, 0);
        drainScoreboard();
        snap_bus.snap_sel = 4'd7;
        snap_bus.word_sel = 2'd0;
        #1;
        expect_val("snap_sel_oob", K_WORD, 0, 0);
        drainScoreboard();

        snap_bus.snap_sel = 4'd1;
        @(posedge clk1);
        #3;
        reset_n = 1'b0;
        #1;
        expect_val("async_rst_cnt", K_COUNT, 1, 0);
        expect_val("async_rst_valid", K_VALID, 0, 0);
        expect_val("async_rst_word", K_WORD, 0, 0);
        drainScoreboard();
        run_en = 4'b0000;
        step(1);
        reset_n = 1'b1;
        step(2);
        expect_val("post_rst_cnt", K_COUNT, 1, 0);
        drainScoreboard();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
